output_port_vc_credit_ctrl: RTL and testbench

Per-output-port controller that owns the downstream-VC resource behind the output port's VC selection and assignment path. It keeps one credit counter and one allocation state machine per downstream VC. It grants idle VCs with credits to head flits under round-robin arbitration. It debits credits when flits leave the port and re-credits them on downstream credit return. It sits between global switch allocation and the output link, and feeds VC selection with per-VC availability.

---
 rtl/output_port_vc_credit_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_output_port_vc_credit_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_vc_credit_ctrl.sv
// ---------------------------------------------------------------------------
// output_port_vc_credit_ctrl
//
// Purpose:
//   Owns the downstream VCs behind one output port. Each VC has a credit
//   counter (free downstream slots) and an allocation state machine
//   (IDLE / ALLOC / ACTIVE). Head flits asking for a VC are granted an idle
//   VC with credit, picked round-robin. Departing flits debit credits and
//   drive the per-VC state; downstream credit returns re-credit.
//
// Handshake:
//   There is no back-pressure. vc_alloc_req_i is a one-cycle request and
//   vc_alloc_gnt_o answers it combinationally in the same cycle.
//   flit_sent_vld_i and credit_ret_vld_i are one-cycle event strobes, each
//   qualifying its own id and flag inputs.
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   vc_alloc_req_i          head flit wants a downstream VC
//   vc_alloc_gnt_o          grant this cycle (combinational)
//   vc_alloc_vc_id_o        granted VC id, 0 when there is no grant
//   flit_sent_*_i           flit leaving the port: valid, VC id, head, tail
//   credit_ret_*_i          downstream freed one slot: valid, VC id
//   vc_credit_avail_o       per-VC credit count > 0
//   vc_idle_o               per-VC state is IDLE
//   err_underflow_o         sticky: flit sent on a VC with zero credits
//   err_overflow_o          sticky: credit returned to a full counter
//   err_protocol_o          sticky: send on an IDLE VC, or head on ACTIVE
// ---------------------------------------------------------------------------
module output_port_vc_credit_ctrl #(
   parameter int OUTPUT_VC_NUM = 4,
   parameter int VC_DEPTH      = 4,
   parameter int VC_ID_W       = (OUTPUT_VC_NUM > 1) ? $clog2(OUTPUT_VC_NUM) : 1,
   parameter int CREDIT_W      = $clog2(VC_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     vc_alloc_req_i,
   output logic                     vc_alloc_gnt_o,
   output logic [VC_ID_W-1:0]       vc_alloc_vc_id_o,
   input  logic                     flit_sent_vld_i,
   input  logic [VC_ID_W-1:0]       flit_sent_vc_id_i,
   input  logic                     flit_sent_head_i,
   input  logic                     flit_sent_tail_i,
   input  logic                     credit_ret_vld_i,
   input  logic [VC_ID_W-1:0]       credit_ret_vc_id_i,
   output logic [OUTPUT_VC_NUM-1:0] vc_credit_avail_o,
   output logic [OUTPUT_VC_NUM-1:0] vc_idle_o,
   output logic                     err_underflow_o,
   output logic                     err_overflow_o,
   output logic                     err_protocol_o
);

   typedef enum logic [1:0] {
      VC_IDLE   = 2'd0,
      VC_ALLOC  = 2'd1,
      VC_ACTIVE = 2'd2
   } vc_state_e;

   localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(VC_DEPTH);
   localparam logic [VC_ID_W-1:0]  LAST_VC     = VC_ID_W'(OUTPUT_VC_NUM - 1);

   vc_state_e           state_q  [OUTPUT_VC_NUM];
   vc_state_e           state_d  [OUTPUT_VC_NUM];
   logic [CREDIT_W-1:0] credit_q [OUTPUT_VC_NUM];
   logic [CREDIT_W-1:0] credit_d [OUTPUT_VC_NUM];
   logic [VC_ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic                err_underflow_q, err_underflow_d;
   logic                err_overflow_q,  err_overflow_d;
   logic                err_protocol_q,  err_protocol_d;

   logic [OUTPUT_VC_NUM-1:0] eligible;
   logic [OUTPUT_VC_NUM-1:0] send_hit;
   logic [OUTPUT_VC_NUM-1:0] ret_hit;
   logic [OUTPUT_VC_NUM-1:0] gnt_hit;
   logic                     gnt_found;
   logic [VC_ID_W-1:0]       gnt_id;
   logic                     gnt;

   // Per-VC decode of the event strobes. Eligibility uses registered state
   // and credit only, so a tail or a credit return takes effect next cycle.
   always_comb begin
      for (int v = 0; v < OUTPUT_VC_NUM; v++) begin
         send_hit[v] = flit_sent_vld_i  && (flit_sent_vc_id_i  == VC_ID_W'(v));
         ret_hit[v]  = credit_ret_vld_i && (credit_ret_vc_id_i == VC_ID_W'(v));
         eligible[v] = (state_q[v] == VC_IDLE) && (credit_q[v] != '0);
      end
   end

   // Round-robin pick: first eligible VC at or after rr_ptr, wrapping.
   always_comb begin
      logic [VC_ID_W-1:0] idx;
      gnt_found = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      for (int i = 0; i < OUTPUT_VC_NUM; i++) begin
         idx = VC_ID_W'((int'(rr_ptr_q) + i) % OUTPUT_VC_NUM);
         if (!gnt_found && eligible[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = idx;
         end
      end
   end

   assign gnt = vc_alloc_req_i && gnt_found;

   always_comb begin
      gnt_hit = '0;
      if (gnt) begin
         gnt_hit[gnt_id] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt) begin
         rr_ptr_d = (gnt_id == LAST_VC) ? '0 : gnt_id + VC_ID_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int v = 0; v < OUTPUT_VC_NUM; v++) begin
            state_q[v]  <= VC_IDLE;
            credit_q[v] <= CREDIT_FULL;
         end
         rr_ptr_q        <= '0;
         err_underflow_q <= 1'b0;
         err_overflow_q  <= 1'b0;
         err_protocol_q  <= 1'b0;
      end else begin
         for (int v = 0; v < OUTPUT_VC_NUM; v++) begin
            state_q[v]  <= state_d[v];
            credit_q[v] <= credit_d[v];
         end
         rr_ptr_q        <= rr_ptr_d;
         err_underflow_q <= err_underflow_d;
         err_overflow_q  <= err_overflow_d;
         err_protocol_q  <= err_protocol_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic: per-VC FSM, credit counters, sticky errors
   // ------------------------------------------------------------------
   always_comb begin
      vc_state_e eff_state;
      err_underflow_d = err_underflow_q;
      err_overflow_d  = err_overflow_q;
      err_protocol_d  = err_protocol_q;
      eff_state       = VC_IDLE;
      for (int v = 0; v < OUTPUT_VC_NUM; v++) begin
         state_d[v]  = state_q[v];
         credit_d[v] = credit_q[v];

         // A VC granted this cycle already counts as ALLOC, so its head
         // flit may leave in the same cycle as the grant.
         eff_state = gnt_hit[v] ? VC_ALLOC : state_q[v];
         state_d[v] = eff_state;

         if (send_hit[v]) begin
            unique case (eff_state)
               VC_IDLE: begin
                  err_protocol_d = 1'b1;
               end
               VC_ALLOC: begin
                  if (flit_sent_head_i) begin
                     state_d[v] = flit_sent_tail_i ? VC_IDLE : VC_ACTIVE;
                  end
               end
               VC_ACTIVE: begin
                  if (flit_sent_head_i) begin
                     err_protocol_d = 1'b1;
                  end else if (flit_sent_tail_i) begin
                     state_d[v] = VC_IDLE;
                  end
               end
               default: begin
                  state_d[v] = VC_IDLE;
               end
            endcase
         end

         // Same-VC send and return cancel out and cannot raise an error.
         if (send_hit[v] && !ret_hit[v]) begin
            if (credit_q[v] == '0) begin
               err_underflow_d = 1'b1;
            end else begin
               credit_d[v] = credit_q[v] - CREDIT_W'(1);
            end
         end else if (ret_hit[v] && !send_hit[v]) begin
            if (credit_q[v] == CREDIT_FULL) begin
               err_overflow_d = 1'b1;
            end else begin
               credit_d[v] = credit_q[v] + CREDIT_W'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      for (int v = 0; v < OUTPUT_VC_NUM; v++) begin
         vc_idle_o[v]         = (state_q[v] == VC_IDLE);
         vc_credit_avail_o[v] = (credit_q[v] != '0);
      end
      vc_alloc_gnt_o   = gnt;
      vc_alloc_vc_id_o = gnt ? gnt_id : '0;
      err_underflow_o  = err_underflow_q;
      err_overflow_o   = err_overflow_q;
      err_protocol_o   = err_protocol_q;
   end

endmodule

// File: tb/tb_output_port_vc_credit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_output_port_vc_credit_ctrl
//
// Directed bench for output_port_vc_credit_ctrl with OUTPUT_VC_NUM = 4 and
// VC_DEPTH = 4. Inputs change 1 ns after the rising edge. Combinational
// grant outputs are sampled 1 ns after the inputs change. Registered
// outputs are sampled 1 ns after the edge that loads them.
// ---------------------------------------------------------------------------
module tb_output_port_vc_credit_ctrl;

   localparam int N    = 4;
   localparam int DEP  = 4;
   localparam int ID_W = 2;
   localparam int CR_W = 3;

   logic            clk;
   logic            rstn;
   logic            vc_alloc_req;
   logic            vc_alloc_gnt;
   logic [ID_W-1:0] vc_alloc_vc_id;
   logic            flit_sent_vld;
   logic [ID_W-1:0] flit_sent_vc_id;
   logic            flit_sent_head;
   logic            flit_sent_tail;
   logic            credit_ret_vld;
   logic [ID_W-1:0] credit_ret_vc_id;
   logic [N-1:0]    vc_credit_avail;
   logic [N-1:0]    vc_idle;
   logic            err_underflow;
   logic            err_overflow;
   logic            err_protocol;

   int n_checks = 0;
   int n_pass   = 0;

   output_port_vc_credit_ctrl #(
      .OUTPUT_VC_NUM(N),
      .VC_DEPTH     (DEP),
      .VC_ID_W      (ID_W),
      .CREDIT_W     (CR_W)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .vc_alloc_req_i    (vc_alloc_req),
      .vc_alloc_gnt_o    (vc_alloc_gnt),
      .vc_alloc_vc_id_o  (vc_alloc_vc_id),
      .flit_sent_vld_i   (flit_sent_vld),
      .flit_sent_vc_id_i (flit_sent_vc_id),
      .flit_sent_head_i  (flit_sent_head),
      .flit_sent_tail_i  (flit_sent_tail),
      .credit_ret_vld_i  (credit_ret_vld),
      .credit_ret_vc_id_i(credit_ret_vc_id),
      .vc_credit_avail_o (vc_credit_avail),
      .vc_idle_o         (vc_idle),
      .err_underflow_o   (err_underflow),
      .err_overflow_o    (err_overflow),
      .err_protocol_o    (err_protocol)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // checker
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // driver tasks
   task automatic clr();
      vc_alloc_req     = 1'b0;
      flit_sent_vld    = 1'b0;
      flit_sent_vc_id  = '0;
      flit_sent_head   = 1'b0;
      flit_sent_tail   = 1'b0;
      credit_ret_vld   = 1'b0;
      credit_ret_vc_id = '0;
   endtask

   task automatic send(input int vc, input logic head, input logic tail);
      flit_sent_vld   = 1'b1;
      flit_sent_vc_id = ID_W'(vc);
      flit_sent_head  = head;
      flit_sent_tail  = tail;
   endtask

   task automatic ret(input int vc);
      credit_ret_vld   = 1'b1;
      credit_ret_vc_id = ID_W'(vc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] credit_of(input int vc);
      return 32'(dut.credit_q[vc]);
   endfunction

   initial begin
      clr();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      #1;
      // reset state
      check("rst_avail", 32'(vc_credit_avail), 32'hF);
      check("rst_idle", 32'(vc_idle), 32'hF);
      check("rst_uf", 32'(err_underflow), 0);
      check("rst_of", 32'(err_overflow), 0);
      check("rst_pe", 32'(err_protocol), 0);
      check("rst_gnt", 32'(vc_alloc_gnt), 0);
      check("rst_id", 32'(vc_alloc_vc_id), 0);
      step();

      // first two requests: VC0 then VC1
      vc_alloc_req = 1'b1;
      #1;
      check("req1_gnt", 32'(vc_alloc_gnt), 1);
      check("req1_id", 32'(vc_alloc_vc_id), 0);
      step();
      check("req1_idle", 32'(vc_idle), 32'b1110);
      check("req2_gnt", 32'(vc_alloc_gnt), 1);
      check("req2_id", 32'(vc_alloc_vc_id), 1);
      step();
      clr();
      check("req2_idle", 32'(vc_idle), 32'b1100);

      // single-flit packet on VC1 right after its grant
      send(1, 1'b1, 1'b1);
      step();
      clr();
      check("ht_idle", 32'(vc_idle), 32'b1110);
      check("ht_cred1", credit_of(1), 3);
      check("ht_pe", 32'(err_protocol), 0);

      // VC2: grant plus head in the same cycle, then bodies and tail
      vc_alloc_req = 1'b1;
      send(2, 1'b1, 1'b0);
      #1;
      check("vc2_gnt_id", 32'(vc_alloc_vc_id), 2);
      step();
      clr();
      check("vc2_idle", 32'(vc_idle), 32'b1010);
      check("vc2_cred_h", credit_of(2), 3);
      send(2, 1'b0, 1'b0);
      step();
      send(2, 1'b0, 1'b0);
      step();
      send(2, 1'b0, 1'b1);
      step();
      clr();
      check("vc2_cred_t", credit_of(2), 0);
      check("vc2_avail", 32'(vc_credit_avail), 32'b1011);
      check("vc2_idle_t", 32'(vc_idle), 32'b1110);
      check("vc2_pe", 32'(err_protocol), 0);

      // VC2 idle but creditless: never granted
      vc_alloc_req = 1'b1;
      #1;
      check("rr3_id", 32'(vc_alloc_vc_id), 3);
      step();
      check("rr0_id", 32'(vc_alloc_vc_id), 1);
      step();
      check("nocred_gnt", 32'(vc_alloc_gnt), 0);
      check("nocred_id", 32'(vc_alloc_vc_id), 0);
      ret(2);
      #1;
      check("ret_same_cyc_gnt", 32'(vc_alloc_gnt), 0);
      step();
      credit_ret_vld = 1'b0;
      check("ret_avail", 32'(vc_credit_avail), 32'hF);
      check("ret_gnt", 32'(vc_alloc_gnt), 1);
      check("ret_id", 32'(vc_alloc_vc_id), 2);
      step();
      clr();
      check("all_busy_idle", 32'(vc_idle), 0);

      // VC0 drained to zero credits, then send+return, then underflow
      send(0, 1'b1, 1'b0);
      step();
      repeat (3) begin
         send(0, 1'b0, 1'b0);
         step();
      end
      clr();
      check("vc0_cred0", credit_of(0), 0);
      check("vc0_avail", 32'(vc_credit_avail), 32'b1110);
      send(0, 1'b0, 1'b0);
      ret(0);
      step();
      clr();
      check("net0_cred", credit_of(0), 0);
      check("net0_uf", 32'(err_underflow), 0);
      send(0, 1'b0, 1'b0);
      step();
      clr();
      check("uf_set", 32'(err_underflow), 1);
      check("uf_cred", credit_of(0), 0);
      step();
      check("uf_sticky", 32'(err_underflow), 1);
      check("uf_pe", 32'(err_protocol), 0);

      // VC3 back to idle, overflow on full counter, body on idle VC
      send(3, 1'b1, 1'b1);
      step();
      clr();
      check("vc3_idle", 32'(vc_idle), 32'b1000);
      check("vc3_cred", credit_of(3), 3);
      ret(3);
      step();
      check("vc3_full", credit_of(3), 4);
      check("of_clear", 32'(err_overflow), 0);
      step();
      clr();
      check("of_set", 32'(err_overflow), 1);
      check("of_cred", credit_of(3), 4);
      send(3, 1'b0, 1'b0);
      step();
      clr();
      check("pe_set", 32'(err_protocol), 1);
      check("pe_idle", 32'(vc_idle), 32'b1000);
      check("pe_cred", credit_of(3), 3);

      // async reset while VC0 is ACTIVE with one credit
      ret(0);
      step();
      clr();
      check("pre_rst_cred0", credit_of(0), 1);
      check("pre_rst_avail", 32'(vc_credit_avail), 32'hF);
      #2 rstn = 1'b0;
      #1;
      check("arst_avail", 32'(vc_credit_avail), 32'hF);
      check("arst_idle", 32'(vc_idle), 32'hF);
      check("arst_uf", 32'(err_underflow), 0);
      check("arst_of", 32'(err_overflow), 0);
      check("arst_pe", 32'(err_protocol), 0);
      check("arst_cred0", credit_of(0), 4);
      check("arst_gnt", 32'(vc_alloc_gnt), 0);
      @(posedge clk);
      #1 rstn = 1'b1;
      vc_alloc_req = 1'b1;
      #1;
      check("post_rst_gnt", 32'(vc_alloc_gnt), 1);
      check("post_rst_id", 32'(vc_alloc_vc_id), 0);
      step();
      clr();
      check("post_rst_idle", 32'(vc_idle), 32'b1110);

      // report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
